turn_input_ctrl: RTL and testbench
==================================

// Module: turn_input_ctrl
// PURPOSE
//  Upstream input stage of the light-cycle game; its outputs drive the player/trail stage.
//  Synchronises and debounces the four active-low push buttons (KEY[3:0]).
//  Turns each press into a single turn request per player, and holds each player's heading (sentido).
//  A request is committed only on the movement tick, so a player makes at most one 90-degree turn per
//  step and can never reverse into its own trail.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles a synchronised level must stay stable before acceptance (10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  INIT_DIR_J1      0       J1 heading after reset/restart (0 right, 1 down, 2 left, 3 up)
//  INIT_DIR_J2      2       J2 heading after reset/restart
// PORTS
//  CLOCK_50     in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high; clears everything
//  reiniciar    in   1  synchronous round restart; headings + pending only
//  KEY          in   4  raw buttons, active-low, asynchronous: [3] J1 ccw, [2] J1 cw, [1] J2 ccw, [0] J2 cw
//  step         in   1  one-cycle movement tick from the player stage
//  key_db       out  4  debounced level, active-high = pressed
//  turn_pulse   out  4  one-cycle pulse on each accepted press edge (bit mapping as KEY)
//  sentido_j1   out  2  committed J1 heading
//  sentido_j2   out  2  committed J2 heading
//  pend_j1      out  1  J1 has a turn queued for the next step
//  pend_j2      out  1  J2 has a turn queued for the next step
// BEHAVIOUR
//  - Reset values: key_db=0, turn_pulse=0, pend_*=0, sentido_j1=INIT_DIR_J1, sentido_j2=INIT_DIR_J2.
//    Sync flops reset to 1 (released). Debounce counters reset to 0.
//  - Sync: each KEY bit is inverted, then passes through a 2-FF synchroniser.
//  - Debounce, per bit:
//    - synced == key_db: counter := 0.
//    - otherwise counter += 1. On the cycle counter == DEBOUNCE_CYCLES-1: key_db toggles, counter := 0.
//    - Latency from raw edge to key_db: 2 + DEBOUNCE_CYCLES cycles.
//    - A glitch shorter than DEBOUNCE_CYCLES produces no change.
//  - turn_pulse[i] is registered and is 1 for exactly one cycle, the cycle after key_db[i] rises.
//    Release generates nothing. Holding a key gives no auto-repeat.
//  - Pending per player: registered {valid, delta}, with delta = -1 (ccw) or +1 (cw).
//    - A ccw/cw pulse while valid=0 loads valid=1 and the delta.
//    - While valid=1, further pulses are dropped; the first request wins.
//    - ccw and cw pulses for the same player in the same cycle are both dropped.
//  - Commit on step=1 with valid=1: sentido := sentido + delta, modulo 4 (3+1 -> 0, 0-1 -> 3).
//    valid := 0 in the same cycle. sentido_* changes the cycle after step.
//  - Pulse and step in the same cycle with valid=0: the pulse is queued and commits on the NEXT step.
//  - step with valid=0: heading unchanged.
//  - Players are fully independent; both may commit on the same step.
//  - reiniciar=1: sentido := INIT_DIR_*, pending cleared; debounce state and key_db are kept.
//    A press still held across reiniciar does not re-pulse.
//  - Priority: reset > reiniciar > commit/queue. Asserting reset mid-debounce aborts the count.
// CONFIGURATION
//  DEBOUNCE_BYPASS_EN defined:
//    - Debounce counters are removed; key_db = synchronised level (latency 2).
//    - Edge/pending/commit logic is unchanged. Intended for fast simulation.
//  DEBOUNCE_BYPASS_EN undefined (default): full debounce as above.
// TESTING  (bench uses DEBOUNCE_CYCLES=4 unless noted)
//  1. Reset, no keys -> sentido_j1=0, sentido_j2=2, key_db=0, turn_pulse=0, pend=0.
//  2. KEY[2] low for 20 cycles, then step -> turn_pulse[2] exactly once at cycle 7 after the edge,
//     pend_j1=1 before step, sentido_j1=1 after step, pend_j1=0.
//  3. KEY[3] low for 2 cycles only -> key_db[3] stays 0, no pulse, sentido_j1 unchanged.
//  4. J1 ccw press then J1 cw press, then one step -> sentido_j1 goes 0->3 only.
//     A second step with no press keeps 3.
//  5. J2 cw pulse coincident with step -> no change on that step; next step -> sentido_j2=3.
//     Four more queued cw turns wrap the heading 3->0->1->2->3.
//  6. reiniciar pulsed with sentido_j1=3 and J2 pending -> sentido 0/2, pend 0,
//     held key_db bits stay 1, no new pulse.
//     Repeat with DEBOUNCE_BYPASS_EN: press latency is 2 cycles.

Source files
------------

// File: rtl/turn_input_ctrl_if.sv
// rtl/turn_input_ctrl_if.sv - bus bundle between the input stage and its driver/consumer
// Signals:
//   reiniciar   round restart request (driver -> input stage)
//   KEY[3:0]    raw active-low buttons (driver -> input stage)
//   step        movement tick (driver -> input stage)
//   key_db      debounced pressed level (input stage -> consumer)
//   turn_pulse  one-cycle accepted-press pulses (input stage -> consumer)
//   sentido_j1  committed J1 heading (input stage -> consumer)
//   sentido_j2  committed J2 heading (input stage -> consumer)
//   pend_j1     J1 turn queued (input stage -> consumer)
//   pend_j2     J2 turn queued (input stage -> consumer)
interface turn_input_ctrl_if;
    logic       reiniciar;
    logic [3:0] KEY;
    logic       step;
    logic [3:0] key_db;
    logic [3:0] turn_pulse;
    logic [1:0] sentido_j1;
    logic [1:0] sentido_j2;
    logic       pend_j1;
    logic       pend_j2;

    modport master (
        output reiniciar, KEY, step,
        input  key_db, turn_pulse, sentido_j1, sentido_j2, pend_j1, pend_j2
    );

    modport slave (
        input  reiniciar, KEY, step,
        output key_db, turn_pulse, sentido_j1, sentido_j2, pend_j1, pend_j2
    );
endinterface

// File: rtl/turn_input_ctrl.sv
// rtl/turn_input_ctrl.sv - button sync/debounce, turn pulses and per-player heading commit
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset     synchronous active-high reset, clears everything
//   bus       turn_input_ctrl_if.slave: reiniciar, KEY, step in; key_db, turn_pulse,
//             sentido_j1, sentido_j2, pend_j1, pend_j2 out
// KEY mapping: [3] J1 ccw, [2] J1 cw, [1] J2 ccw, [0] J2 cw.
// Optional build macro DEBOUNCE_BYPASS_EN: removes the debounce counters, key_db follows
// the synchronised level directly.
module turn_input_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         CNT_W           = 20,
    parameter logic [1:0] INIT_DIR_J1     = 2'd0,
    parameter logic [1:0] INIT_DIR_J2     = 2'd2
) (
    input logic              CLOCK_50,
    input logic              reset,
    turn_input_ctrl_if.slave bus
);

    // Two-FF synchroniser on the raw (active-low) level; reset value 1 = released.
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] pressed;
    logic [3:0] key_db_w;

    always_comb begin
        sync1_d = bus.KEY;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pressed = ~sync2_q;

`ifndef DEBOUNCE_BYPASS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;

        // Any return to the accepted level restarts the count, so only a level that
        // holds for DEBOUNCE_CYCLES consecutive cycles is accepted.
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (pressed[g] == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign key_db_w[g] = db_q;
    end
`else
    assign key_db_w = pressed;
`endif

    // Rising-edge detect on the debounced level; the pulse lands the cycle after key_db rises.
    logic [3:0] key_prev_q, key_prev_d;
    logic [3:0] turn_pulse_q, turn_pulse_d;

    always_comb begin
        key_prev_d   = key_db_w;
        turn_pulse_d = key_db_w & ~key_prev_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_prev_q   <= 4'h0;
            turn_pulse_q <= 4'h0;
        end else begin
            key_prev_q   <= key_prev_d;
            turn_pulse_q <= turn_pulse_d;
        end
    end

    // Returns {sentido, valid, cw}. A commit consumes the slot, so a pulse arriving on the
    // committing step is dropped; a pulse on a step with an empty slot is queued instead.
    function automatic logic [3:0] pend_next(
        input logic [1:0] sentido,
        input logic       valid,
        input logic       cw_sel,
        input logic       ccw_p,
        input logic       cw_p,
        input logic       step
    );
        logic [1:0] s_n;
        logic       v_n;
        logic       c_n;
        s_n = sentido;
        v_n = valid;
        c_n = cw_sel;
        if (step && valid) begin
            s_n = sentido + (cw_sel ? 2'd1 : 2'd3);
            v_n = 1'b0;
        end else if (!valid && (ccw_p ^ cw_p)) begin
            v_n = 1'b1;
            c_n = cw_p;
        end
        return {s_n, v_n, c_n};
    endfunction

    logic [1:0] sentido_j1_q, sentido_j1_d;
    logic [1:0] sentido_j2_q, sentido_j2_d;
    logic       valid_j1_q, valid_j1_d;
    logic       valid_j2_q, valid_j2_d;
    logic       cw_j1_q, cw_j1_d;
    logic       cw_j2_q, cw_j2_d;

    always_comb begin
        {sentido_j1_d, valid_j1_d, cw_j1_d} = pend_next(sentido_j1_q, valid_j1_q, cw_j1_q,
                                                        turn_pulse_q[3], turn_pulse_q[2], bus.step);
        {sentido_j2_d, valid_j2_d, cw_j2_d} = pend_next(sentido_j2_q, valid_j2_q, cw_j2_q,
                                                        turn_pulse_q[1], turn_pulse_q[0], bus.step);
        // Round restart leaves debounce/edge state alone so a held key cannot re-pulse.
        if (bus.reiniciar) begin
            sentido_j1_d = INIT_DIR_J1;
            sentido_j2_d = INIT_DIR_J2;
            valid_j1_d   = 1'b0;
            valid_j2_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sentido_j1_q <= INIT_DIR_J1;
            sentido_j2_q <= INIT_DIR_J2;
            valid_j1_q   <= 1'b0;
            valid_j2_q   <= 1'b0;
            cw_j1_q      <= 1'b0;
            cw_j2_q      <= 1'b0;
        end else begin
            sentido_j1_q <= sentido_j1_d;
            sentido_j2_q <= sentido_j2_d;
            valid_j1_q   <= valid_j1_d;
            valid_j2_q   <= valid_j2_d;
            cw_j1_q      <= cw_j1_d;
            cw_j2_q      <= cw_j2_d;
        end
    end

    assign bus.key_db     = key_db_w;
    assign bus.turn_pulse = turn_pulse_q;
    assign bus.sentido_j1 = sentido_j1_q;
    assign bus.sentido_j2 = sentido_j2_q;
    assign bus.pend_j1    = valid_j1_q;
    assign bus.pend_j2    = valid_j2_q;

endmodule

// File: tb/tb_turn_input_ctrl.sv
// tb/tb_turn_input_ctrl.sv - self-checking bench for turn_input_ctrl
module tb_turn_input_ctrl;

    localparam int DB = 4;
`ifdef DEBOUNCE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 2 + DB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_input_ctrl_if tif();

    turn_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3),
        .INIT_DIR_J1(2'd0),
        .INIT_DIR_J2(2'd2)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(tif)
    );

    typedef struct {
        logic [3:0] key;
        logic       step;
        logic       rein;
        int         ncyc;
        logic [3:0] db;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       p1;
        logic       p2;
        int         pc[4];
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   pc[4];
    int   pcnt[4];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] tp;
        @(posedge clk);
        #1;
        cyc++;
        tp = tif.turn_pulse;
        if (tp[0]) pcnt[0]++;
        if (tp[1]) pcnt[1]++;
        if (tp[2]) pcnt[2]++;
        if (tp[3]) pcnt[3]++;
    endtask

    function automatic void add(input logic [3:0] key, input logic st, input logic rn, input int n,
                                input logic [3:0] db, input logic [1:0] s1, input logic [1:0] s2,
                                input logic p1, input logic p2);
        vec_t v;
        v.key = key; v.step = st; v.rein = rn; v.ncyc = n;
        v.db = db; v.s1 = s1; v.s2 = s2; v.p1 = p1; v.p2 = p2;
        v.pc = pc;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        int   s;
        int   hit;

        for (int b = 0; b < 4; b++) begin pc[b] = 0; pcnt[b] = 0; end

        // Idle and baseline
        add(4'hF, 0, 0, 3, 4'b0000, 2'd0, 2'd2, 0, 0);
        // J1 cw held, then step
        pc[2]++;
        add(4'hB, 0, 0, 20, 4'b0100, 2'd0, 2'd2, 1, 0);
        add(4'hB, 1, 0, 1, 4'b0100, 2'd1, 2'd2, 0, 0);
        add(4'hF, 0, 0, 10, 4'b0000, 2'd1, 2'd2, 0, 0);
`ifndef DEBOUNCE_BYPASS_EN
        // Short glitch on J1 ccw is rejected
        add(4'h7, 0, 0, 2, 4'b0000, 2'd1, 2'd2, 0, 0);
        add(4'hF, 0, 0, 10, 4'b0000, 2'd1, 2'd2, 0, 0);
`endif
        // Restart, then ccw then cw: first request wins
        add(4'hF, 0, 1, 2, 4'b0000, 2'd0, 2'd2, 0, 0);
        pc[3]++;
        add(4'h7, 0, 0, 10, 4'b1000, 2'd0, 2'd2, 1, 0);
        add(4'hF, 0, 0, 10, 4'b0000, 2'd0, 2'd2, 1, 0);
        pc[2]++;
        add(4'hB, 0, 0, 10, 4'b0100, 2'd0, 2'd2, 1, 0);
        add(4'hF, 0, 0, 10, 4'b0000, 2'd0, 2'd2, 1, 0);
        add(4'hF, 1, 0, 1, 4'b0000, 2'd3, 2'd2, 0, 0);
        add(4'hF, 1, 0, 1, 4'b0000, 2'd3, 2'd2, 0, 0);
        // J2 cw pulse coincident with step: queued, commits on the next step
        pc[0]++;
        add(4'hE, 0, 0, LAT + 1, 4'b0001, 2'd3, 2'd2, 0, 0);
        add(4'hE, 1, 0, 1, 4'b0001, 2'd3, 2'd2, 0, 1);
        add(4'hF, 0, 0, 8, 4'b0000, 2'd3, 2'd2, 0, 1);
        add(4'hF, 1, 0, 1, 4'b0000, 2'd3, 2'd3, 0, 0);
        // Four more cw turns wrap 3->0->1->2->3
        for (int k = 0; k < 4; k++) begin
            pc[0]++;
            add(4'hE, 0, 0, 10, 4'b0001, 2'd3, 2'((3 + k) % 4), 0, 1);
            add(4'hF, 0, 0, 8, 4'b0000, 2'd3, 2'((3 + k) % 4), 0, 1);
            add(4'hF, 1, 0, 1, 4'b0000, 2'd3, 2'((4 + k) % 4), 0, 0);
        end
        // Restart with J1 at 3, J2 pending and key still held: no re-pulse
        pc[0]++;
        add(4'hE, 0, 0, 10, 4'b0001, 2'd3, 2'd3, 0, 1);
        add(4'hE, 0, 1, 1, 4'b0001, 2'd0, 2'd2, 0, 0);
        add(4'hE, 0, 0, 10, 4'b0001, 2'd0, 2'd2, 0, 0);
        add(4'hF, 0, 0, 8, 4'b0000, 2'd0, 2'd2, 0, 0);
        // Both players commit on the same step
        pc[2]++; pc[1]++;
        add(4'h9, 0, 0, 10, 4'b0110, 2'd0, 2'd2, 1, 1);
        add(4'hF, 0, 0, 8, 4'b0000, 2'd0, 2'd2, 1, 1);
        add(4'hF, 1, 0, 1, 4'b0000, 2'd1, 2'd1, 0, 0);
        // J1 ccw and cw in the same cycle are both dropped
        pc[3]++; pc[2]++;
        add(4'h3, 0, 0, 10, 4'b1100, 2'd1, 2'd1, 0, 0);
        add(4'hF, 0, 0, 8, 4'b0000, 2'd1, 2'd1, 0, 0);
        add(4'hF, 1, 0, 1, 4'b0000, 2'd1, 2'd1, 0, 0);
        // Two J1 ccw turns: 1->0->3
        for (int k = 0; k < 2; k++) begin
            pc[3]++;
            add(4'h7, 0, 0, 10, 4'b1000, 2'((5 - k) % 4), 2'd1, 1, 0);
            add(4'hF, 0, 0, 8, 4'b0000, 2'((5 - k) % 4), 2'd1, 1, 0);
            add(4'hF, 1, 0, 1, 4'b0000, 2'((4 - k) % 4), 2'd1, 0, 0);
        end

        // Reset state
        tif.KEY = 4'hF; tif.step = 1'b0; tif.reiniciar = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_s1", 32'(tif.sentido_j1), 32'd0);
        chk("rst_s2", 32'(tif.sentido_j2), 32'd2);
        chk("rst_db", 32'(tif.key_db), 32'd0);
        chk("rst_pulse", 32'(tif.turn_pulse), 32'd0);
        chk("rst_pend", 32'({tif.pend_j1, tif.pend_j2}), 32'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            exp_q.push_back(v);
            tif.KEY = v.key; tif.step = v.step; tif.reiniciar = v.rein;
            tick();
            tif.step = 1'b0; tif.reiniciar = 1'b0;
            repeat (v.ncyc - 1) tick();
            e = exp_q.pop_front();
            chk($sformatf("v%0d_db", i), 32'(tif.key_db), 32'(e.db));
            chk($sformatf("v%0d_s1", i), 32'(tif.sentido_j1), 32'(e.s1));
            chk($sformatf("v%0d_s2", i), 32'(tif.sentido_j2), 32'(e.s2));
            chk($sformatf("v%0d_p1", i), 32'(tif.pend_j1), 32'(e.p1));
            chk($sformatf("v%0d_p2", i), 32'(tif.pend_j2), 32'(e.p2));
            for (int b = 0; b < 4; b++)
                chk($sformatf("v%0d_pc%0d", i, b), 32'(pcnt[b]), 32'(e.pc[b]));
        end

        // Exact pulse timing after a clean press of KEY[2]
        tif.KEY = 4'hF;
        rst = 1'b1; tick(); rst = 1'b0;
        s = cyc;
        hit = -1;
        tif.KEY = 4'hB;
        for (int n = 0; n < 30 && hit < 0; n++) begin
            tick();
            if (tif.turn_pulse[2]) hit = cyc - s;
        end
        chk("pulse_cycle", 32'(hit), 32'(LAT + 1));
        tick();
        chk("pulse_width", 32'(tif.turn_pulse), 32'd0);
        tif.KEY = 4'hF;
        repeat (10) tick();

        // Reset mid-debounce aborts the count; acceptance restarts from scratch
        tif.KEY = 4'h7;
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_db0", 32'(tif.key_db), 32'd0);
        repeat (LAT - 1) tick();
        chk("abort_db_early", 32'(tif.key_db), 32'd0);
        tick();
        chk("abort_db_late", 32'(tif.key_db), 32'b1000);
        tif.KEY = 4'hF;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
